// File: rtl/fetch_queue_pkg.sv
// Shared CPU constants used by the fetch queue: default widths, the zero
// word and the NOP encoding shown on the decode side during a bubble.
package fetch_queue_pkg;

  localparam int ADDR_W_DEFAULT = 32;
  localparam int INST_W_DEFAULT = 32;

  // Widest word any CPU datapath uses; narrower users cast down.
  localparam logic [63:0] ZERO_WORD = 64'h0;

  // Bubble instruction; this core encodes NOP as the all-zero word.
  localparam logic [63:0] NOP_INST = 64'h0;

endpackage

// File: rtl/fetch_queue_ram.sv
// Fetch queue storage: DEPTH entries, one synchronous write port, one
// asynchronous read port. Contents are not reset; validity is tracked by
// the count in the parent.
module fetch_queue_ram #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 64,
  parameter int ADDR_B = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_B-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_B-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed slot on an enqueue.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode circular FIFO.
// Optional build macro: FETCH_QUEUE_BYPASS_EN -- when the queue is empty an
// incoming entry is forwarded combinationally to decode, and consumed
// without being stored if decode is ready.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready on the same side, and ready is
// registered-state only (count/flush/reset), so a slot freed by a dequeue
// becomes visible to the fetch side one cycle later.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int INST_W = INST_W_DEFAULT,
  parameter int DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     if_valid,
  input  logic [ADDR_W-1:0]        if_program_counter,
  input  logic [INST_W-1:0]        if_instruction,
  output logic                     if_ready,
  input  logic                     flush_input,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [ADDR_W-1:0]        id_program_counter,
  output logic [INST_W-1:0]        id_instruction,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + INST_W;

  localparam logic [ADDR_W-1:0] PC_ZERO  = ADDR_W'(ZERO_WORD);
  localparam logic [INST_W-1:0] INST_NOP = INST_W'(NOP_INST);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             head_valid;
  logic             enq;
  logic             deq;
  logic             bypass;
  logic             bypass_take;
  logic             ram_we;
  logic [ENT_W-1:0] ram_rdata;

  assign head_valid = (count != '0);

  // The fetch side is ready only with a free slot, no flush and no reset.
  assign if_ready = !reset && (count != CNT_FULL) && !flush_input;
  assign enq      = if_valid && if_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass      = !reset && !flush_input && !head_valid && if_valid;
  assign bypass_take = bypass && id_ready;
`else
  assign bypass      = 1'b0;
  assign bypass_take = 1'b0;
`endif

  // Only stored entries are popped; a bypassed entry never touches the RAM.
  assign deq    = head_valid && id_ready && !flush_input;
  assign ram_we = enq && !bypass_take;

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata ({if_program_counter, if_instruction}),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // Head presentation: stored head, else bypassed input, else a bubble.
  always_comb begin
    id_valid           = 1'b0;
    id_program_counter = PC_ZERO;
    id_instruction     = INST_NOP;
    if (!reset) begin
      if (head_valid) begin
        id_valid           = 1'b1;
        id_program_counter = ram_rdata[ENT_W-1:INST_W];
        id_instruction     = ram_rdata[INST_W-1:0];
      end else if (bypass) begin
        id_valid           = 1'b1;
        id_program_counter = if_program_counter;
        id_instruction     = if_instruction;
      end
    end
  end

  // Pointer and count update; flush wins over any concurrent transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_input) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (ram_we) wr_ptr <= wr_ptr + 1'b1;
      if (deq)    rd_ptr <= rd_ptr + 1'b1;
      if (ram_we && !deq)      count <= count + 1'b1;
      else if (!ram_we && deq) count <= count - 1'b1;
    end
  end

  assign occupancy = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_program_counter = '0;
  logic [31:0] if_instruction = '0;
  logic        if_ready;
  logic        flush_input = 1'b0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_program_counter;
  logic [31:0] id_instruction;
  logic [2:0]  occupancy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model contents: {pc, instruction}, head at index 0.
  logic [63:0] exp_q[$];

  fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
    .clock              (clock),
    .reset              (reset),
    .if_valid           (if_valid),
    .if_program_counter (if_program_counter),
    .if_instruction     (if_instruction),
    .if_ready           (if_ready),
    .flush_input        (flush_input),
    .id_ready           (id_ready),
    .id_valid           (id_valid),
    .id_program_counter (id_program_counter),
    .id_instruction     (id_instruction),
    .occupancy          (occupancy)
  );

  // Clock generation
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  // Drive one cycle, check outputs mid-cycle against the model, then apply
  // the model's transition at the edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic fl);
    logic        ready_e, byp, valid_e, deq_e, enq_e;
    logic [31:0] pc_e, ins_e;
    int          sz;
    if_valid = v; if_program_counter = pc; if_instruction = ins;
    id_ready = rdy; flush_input = fl;
    #2;
    sz      = exp_q.size();
    ready_e = (sz < DEPTH) && !fl;
    byp     = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp     = (sz == 0) && v && !fl;
`endif
    valid_e = (sz != 0) || byp;
    pc_e    = (sz != 0) ? exp_q[0][63:32] : (byp ? pc  : 32'h0);
    ins_e   = (sz != 0) ? exp_q[0][31:0]  : (byp ? ins : 32'h0);
    chk("if_ready",  {63'h0, if_ready}, {63'h0, ready_e});
    chk("id_valid",  {63'h0, id_valid}, {63'h0, valid_e});
    chk("id_pc",     {32'h0, id_program_counter}, {32'h0, pc_e});
    chk("id_inst",   {32'h0, id_instruction},     {32'h0, ins_e});
    chk("occupancy", {61'h0, occupancy}, 64'(sz));
    if (fl) begin
      exp_q.delete();
    end else begin
      deq_e = valid_e && rdy;
      enq_e = v && ready_e;
      if (!(byp && rdy)) begin
        if (deq_e) void'(exp_q.pop_front());
        if (enq_e) exp_q.push_back({pc, ins});
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_if_ready", {63'h0, if_ready}, 64'h0);
    chk("rst_id_valid", {63'h0, id_valid}, 64'h0);
    chk("rst_occ",      {61'h0, occupancy}, 64'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("post_rst_if_ready", {63'h0, if_ready}, 64'h1);

    // Fill with decode stalled
    for (int i = 0; i < 4; i++) begin
      logic [31:0] p;
      p = 32'h100 + 32'(4 * i);
      step(1'b1, p, inst_of(p), 1'b0, 1'b0);
    end
    #1;
    chk("fill_occ",      {61'h0, occupancy}, 64'd4);
    chk("fill_if_ready", {63'h0, if_ready}, 64'h0);
    chk("fill_head",     {32'h0, id_program_counter}, 64'h100);

    // Drain while full: offer 0x110 twice, accepted only on the second cycle
    step(1'b1, 32'h110, inst_of(32'h110), 1'b1, 1'b0);
    chk("drain_head", {32'h0, id_program_counter}, 64'h104);
    step(1'b1, 32'h110, inst_of(32'h110), 1'b0, 1'b0);
    chk("drain_accept_occ", {61'h0, occupancy}, 64'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("drain_empty", {63'h0, id_valid}, 64'h0);

    // Flush with three entries and a concurrent offer
    for (int i = 0; i < 3; i++) begin
      logic [31:0] p;
      p = 32'h180 + 32'(4 * i);
      step(1'b1, p, inst_of(p), 1'b0, 1'b0);
    end
    step(1'b1, 32'h200, inst_of(32'h200), 1'b1, 1'b1);
    if_valid = 1'b0; flush_input = 1'b0; id_ready = 1'b0;
    #1;
    chk("flush_occ",   {61'h0, occupancy}, 64'h0);
    chk("flush_valid", {63'h0, id_valid}, 64'h0);
    chk("flush_inst",  {32'h0, id_instruction}, 64'h0);
    idle();

    // Wrap-around: ten push/pop pairs, order kept, occupancy stays <= 1
    for (int i = 0; i < 10; i++) begin
      logic [31:0] p;
      p = 32'h400 + 32'(4 * i);
      step(1'b1, p, inst_of(p), 1'b1, 1'b0);
      chk("wrap_occ_le1", {63'h0, (occupancy <= 3'd1)}, 64'h1);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges with two entries
    step(1'b1, 32'h500, inst_of(32'h500), 1'b0, 1'b0);
    step(1'b1, 32'h504, inst_of(32'h504), 1'b0, 1'b0);
    if_valid = 1'b0;
    #1;
    chk("pre_arst_occ", {61'h0, occupancy}, 64'd2);
    reset = 1'b1;
    #1;
    chk("arst_valid", {63'h0, id_valid}, 64'h0);
    chk("arst_pc",    {32'h0, id_program_counter}, 64'h0);
    chk("arst_inst",  {32'h0, id_instruction}, 64'h0);
    chk("arst_occ",   {61'h0, occupancy}, 64'h0);
    chk("arst_ready", {63'h0, if_ready}, 64'h0);
    exp_q.delete();
    @(posedge clock); #2;
    reset = 1'b0;
    @(posedge clock); #1;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Bypass from empty: visible the same cycle, never stored
    if_valid = 1'b1; if_program_counter = 32'h300;
    if_instruction = inst_of(32'h300); id_ready = 1'b1;
    #1;
    chk("byp_valid", {63'h0, id_valid}, 64'h1);
    chk("byp_pc",    {32'h0, id_program_counter}, 64'h300);
    step(1'b1, 32'h300, inst_of(32'h300), 1'b1, 1'b0);
    if_valid = 1'b0; id_ready = 1'b0;
    #1;
    chk("byp_occ", {61'h0, occupancy}, 64'h0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] p;
      p = $urandom;
      step(1'($urandom_range(0, 1)), p, $urandom, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case the sequence stalls.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, program-counter width.
REQ-002 SHALL have parameter INST_W, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, entry count; legal values are powers of two >= 2.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port if_valid  input  1  fetch stage presents an entry.
REQ-007 SHALL have port if_program_counter  input  ADDR_W  PC of the presented entry.
REQ-008 SHALL have port if_instruction  input  INST_W  instruction of the presented entry.
REQ-009 SHALL have port if_ready  output  1  queue accepts an entry this cycle.
REQ-010 SHALL have port flush_input  input  1  discard all entries (branch or exception redirect).
REQ-011 SHALL have port id_ready  input  1  decode consumes the head entry this cycle (low = decode stall).
REQ-012 SHALL have port id_valid  output  1  head entry valid.
REQ-013 SHALL have port id_program_counter  output  ADDR_W  head PC.
REQ-014 SHALL have port id_instruction  output  INST_W  head instruction.
REQ-015 SHALL have port occupancy  output  $clog2(DEPTH)+1  current entry count.

Function
REQ-016 SHALL be a circular FIFO: write pointer, read pointer and count, each wrapping modulo DEPTH (count 0..DEPTH).
REQ-017 SHALL assert if_ready iff count < DEPTH and flush_input is low; enqueue occurs iff if_valid && if_ready.
REQ-018 SHALL dequeue iff id_valid && id_ready; a dequeue frees a slot visible only in the next cycle, so when full if_ready stays low in the dequeue cycle.
REQ-019 SHALL, on simultaneous enqueue and dequeue, leave count unchanged and advance both pointers.
REQ-020 SHALL drive id_valid = (count != 0); id_program_counter and id_instruction show the head entry when valid, else all zeros (bubble, NOP word).
REQ-021 SHALL have one-cycle latency: an entry enqueued at edge N appears at the outputs after edge N (non-bypass build).
REQ-022 SHALL keep head outputs stable while id_valid && !id_ready.
REQ-023 SHALL, when flush_input is high at an edge, set count and both pointers to 0, drop any concurrent enqueue and dequeue, and present zero outputs after that edge.
REQ-024 SHALL ignore if_program_counter and if_instruction when if_valid is low.
REQ-025 SHALL never overflow or underflow; enqueue when full and dequeue when empty are impossible by construction.

Reset
REQ-026 SHALL, while reset is high, immediately force count 0, pointers 0, id_valid 0, id_program_counter 0, id_instruction 0, occupancy 0, if_ready 0.
REQ-027 SHALL take effect mid-operation, discarding all entries without waiting for a clock edge; storage contents need not be cleared.
REQ-028 SHALL assert if_ready in the first cycle after reset deassertion.

Configuration
REQ-029 SHALL support macro FETCH_QUEUE_BYPASS_EN.
REQ-030 SHALL, with FETCH_QUEUE_BYPASS_EN defined, when count == 0 and if_valid is high, drive id_valid/id_program_counter/id_instruction combinationally from the if_* inputs; if id_ready is also high the entry is consumed without being written and count stays 0.
REQ-031 SHALL, without FETCH_QUEUE_BYPASS_EN, have no combinational path from if_* to id_* (REQ-021 applies).
REQ-032 SHALL keep flush priority in both builds: flush_input high suppresses the bypass (id_valid 0).

Structure
REQ-033 SHALL take ZeroWord, default ADDR_W/INST_W and the NOP encoding from the shared cpu package/defines, not local literals.
REQ-034 SHALL place storage in sub-module fetch_queue_ram (DEPTH x (ADDR_W+INST_W), one write port, one asynchronous read port, no reset).

Verification
REQ-035 SHALL cover fill: reset, push PCs 0x100,0x104,0x108,0x10C with id_ready=0 -> occupancy 4, if_ready 0, head PC 0x100.
REQ-036 SHALL cover drain while full: full queue, id_ready=1, if_valid=1 PC 0x110 -> no enqueue that cycle, head 0x104 next, 0x110 accepted next cycle.
REQ-037 SHALL cover flush: 3 entries, flush_input=1 with if_valid=1 PC 0x200 -> occupancy 0, id_valid 0, id_instruction 0x00000000, 0x200 dropped.
REQ-038 SHALL cover wrap-around: 10 push/pop pairs with DEPTH=4 -> PCs exit in order, occupancy never exceeds 1.
REQ-039 SHALL cover async reset: assert reset between edges with 2 entries -> outputs 0 before next edge.
REQ-040 SHALL cover bypass build: empty, if_valid=1 PC 0x300, id_ready=1 -> id_valid 1 same cycle, occupancy stays 0.
